// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/address/link results plus a 32-iteration
// shift-add multiplier that stalls the front end while it runs. All results
// are registered into the EX/MEM outputs.
module ex_stage #(
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          MUL_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_in,
  input  logic        in_valid,
  input  logic [31:0] src_data_a_in,
  input  logic [31:0] src_data_b_in,
  input  logic [31:0] imm_value_in,
  input  logic [4:0]  dest_reg_in,
  input  logic [31:0] pc_in,
  input  logic [3:0]  ex_control_in,
  input  logic        reg_write_en_in,
  input  logic        mem_write_en_in,
  input  logic        memory_enable_in,
  output logic        stall_out,
  output logic        out_valid,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  dest_reg_out,
  output logic [31:0] pc_out,
  output logic        reg_write_en_out,
  output logic        mem_write_en_out,
  output logic        memory_enable_out
);

  // state | meaning
  // IDLE  | single-cycle ops registered directly; a multiply is captured here
  // BUSY  | one partial product per cycle, result loaded on the last count
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic        op_hi;
  logic [4:0]  cap_dest;
  logic [31:0] cap_pc;
  logic        cap_rwe;
  logic        cap_mwe;
  logic        cap_men;

  logic        is_mul;
  logic        last;
  logic [63:0] addend;
  logic [63:0] acc_sum;
  logic [31:0] alu_res;

  // Memory accesses always compute an address, so they can never start a multiply.
  assign is_mul = !memory_enable_in &&
                  (ex_control_in == 4'b1101 || ex_control_in == 4'b1110);
  assign last   = (count == 5'(MUL_CYCLES - 1));

  assign stall_out = (((state == IDLE) && in_valid && is_mul) ||
                      ((state == BUSY) && !last)) && !flush_in;

  // Partial product for the current multiplier bit.
  always_comb begin
    addend  = mplier[count] ? ({32'd0, mcand} << count) : 64'd0;
    acc_sum = acc + addend;
  end

  // Single-cycle result; a memory access overrides the op code with A+I.
  always_comb begin
    alu_res = 32'd0;
    if (memory_enable_in) begin
      alu_res = src_data_a_in + imm_value_in;
    end else begin
      case (ex_control_in)
        4'b0000: alu_res = src_data_a_in + src_data_b_in;
        4'b0001: alu_res = src_data_a_in - src_data_b_in;
        4'b0010: alu_res = src_data_a_in & src_data_b_in;
        4'b0011: alu_res = src_data_a_in | src_data_b_in;
        4'b0100: alu_res = src_data_a_in ^ src_data_b_in;
        4'b0101: alu_res = src_data_a_in << src_data_b_in[4:0];
        4'b0110: alu_res = src_data_a_in >> src_data_b_in[4:0];
        4'b0111: alu_res = 32'($signed(src_data_a_in) >>> src_data_b_in[4:0]);
        4'b1000: alu_res = {31'd0, $signed(src_data_a_in) < $signed(src_data_b_in)};
        4'b1001: alu_res = {31'd0, src_data_a_in < src_data_b_in};
        4'b1010: alu_res = src_data_a_in + imm_value_in;
        4'b1011: alu_res = imm_value_in;
        4'b1100: alu_res = pc_in + imm_value_in;
        4'b1111: alu_res = pc_in + 32'd4;
        default: alu_res = 32'd0;
      endcase
    end
  end

  // Sequencer and EX/MEM output register; every edge defaults to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      count             <= 5'd0;
      acc               <= 64'd0;
      mcand             <= 32'd0;
      mplier            <= 32'd0;
      op_hi             <= 1'b0;
      cap_dest          <= 5'd0;
      cap_pc            <= 32'd0;
      cap_rwe           <= 1'b0;
      cap_mwe           <= 1'b0;
      cap_men           <= 1'b0;
      out_valid         <= 1'b0;
      reg_write_en_out  <= 1'b0;
      mem_write_en_out  <= 1'b0;
      memory_enable_out <= 1'b0;
      alu_result_out    <= RESET_VALUE;
      store_data_out    <= RESET_VALUE;
      pc_out            <= RESET_VALUE;
      dest_reg_out      <= 5'd0;
    end else begin
      out_valid         <= 1'b0;
      reg_write_en_out  <= 1'b0;
      mem_write_en_out  <= 1'b0;
      memory_enable_out <= 1'b0;
      if (flush_in) begin
        state <= IDLE;
        count <= 5'd0;
        acc   <= 64'd0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid && is_mul) begin
              mcand    <= src_data_a_in;
              mplier   <= src_data_b_in;
              op_hi    <= ex_control_in[1];
              cap_dest <= dest_reg_in;
              cap_pc   <= pc_in;
              cap_rwe  <= reg_write_en_in;
              cap_mwe  <= mem_write_en_in;
              cap_men  <= memory_enable_in;
              acc      <= 64'd0;
              count    <= 5'd0;
              state    <= BUSY;
            end else if (in_valid) begin
              out_valid         <= 1'b1;
              alu_result_out    <= alu_res;
              store_data_out    <= src_data_b_in;
              dest_reg_out      <= dest_reg_in;
              pc_out            <= pc_in;
              reg_write_en_out  <= reg_write_en_in;
              mem_write_en_out  <= mem_write_en_in;
              memory_enable_out <= memory_enable_in;
            end
          end
          BUSY: begin
            acc   <= acc_sum;
            count <= count + 5'd1;
            if (last) begin
              out_valid         <= 1'b1;
              alu_result_out    <= op_hi ? acc_sum[63:32] : acc_sum[31:0];
              store_data_out    <= mplier;
              dest_reg_out      <= cap_dest;
              pc_out            <= cap_pc;
              reg_write_en_out  <= cap_rwe;
              mem_write_en_out  <= cap_mwe;
              memory_enable_out <= cap_men;
              count             <= 5'd0;
              state             <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes expected EX/MEM contents
// with the cycle they must appear in; a negedge monitor pops and compares.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_in;
  logic        in_valid;
  logic [31:0] src_data_a_in;
  logic [31:0] src_data_b_in;
  logic [31:0] imm_value_in;
  logic [4:0]  dest_reg_in;
  logic [31:0] pc_in;
  logic [3:0]  ex_control_in;
  logic        reg_write_en_in;
  logic        mem_write_en_in;
  logic        memory_enable_in;
  logic        stall_out;
  logic        out_valid;
  logic [31:0] alu_result_out;
  logic [31:0] store_data_out;
  logic [4:0]  dest_reg_out;
  logic [31:0] pc_out;
  logic        reg_write_en_out;
  logic        mem_write_en_out;
  logic        memory_enable_out;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush_in(flush_in), .in_valid(in_valid),
    .src_data_a_in(src_data_a_in), .src_data_b_in(src_data_b_in),
    .imm_value_in(imm_value_in), .dest_reg_in(dest_reg_in), .pc_in(pc_in),
    .ex_control_in(ex_control_in), .reg_write_en_in(reg_write_en_in),
    .mem_write_en_in(mem_write_en_in), .memory_enable_in(memory_enable_in),
    .stall_out(stall_out), .out_valid(out_valid),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .dest_reg_out(dest_reg_out), .pc_out(pc_out),
    .reg_write_en_out(reg_write_en_out), .mem_write_en_out(mem_write_en_out),
    .memory_enable_out(memory_enable_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rwe;
    logic        mwe;
    logic        men;
  } exp_t;

  exp_t sb[$];
  int   sb_cyc[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid output must match the head of the scoreboard in
  // value and in cycle; every bubble must have its enables cleared.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        exp_t got;
        got = '{alu_result_out, store_data_out, dest_reg_out, pc_out,
                reg_write_en_out, mem_write_en_out, memory_enable_out};
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: got res %h at cycle %0d, expected no output", alu_result_out, cyc);
        end else begin
          exp_t e;
          int   ec;
          e  = sb.pop_front();
          ec = sb_cyc.pop_front();
          if (got !== e || cyc != ec) begin
            n_err++;
            $display("FAIL result: got %h at cycle %0d, expected %h at cycle %0d", got, cyc, e, ec);
          end
        end
      end else begin
        check("bubble_enables", {29'd0, reg_write_en_out, mem_write_en_out, memory_enable_out}, 32'd0);
      end
    end
  end

  task automatic set_in(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                        input logic rwe, input logic mwe, input logic men);
    in_valid = 1'b1; ex_control_in = ctrl; src_data_a_in = a; src_data_b_in = b;
    imm_value_in = imm; pc_in = pc; dest_reg_in = rd;
    reg_write_en_in = rwe; mem_write_en_in = mwe; memory_enable_in = men;
  endtask

  // Single-cycle op: result due in the next cycle.
  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                       input logic rwe, input logic mwe, input logic men,
                       input logic [31:0] exp_res);
    @(posedge clk); #1;
    set_in(ctrl, a, b, imm, pc, rd, rwe, mwe, men);
    sb.push_back('{exp_res, b, rd, pc, rwe, mwe, men});
    sb_cyc.push_back(cyc + 1);
    #1 check("no_stall_single", {31'd0, stall_out}, 32'd0);
  endtask

  // Multiply: stall for cycles N..N+31, release in N+32, result in N+33.
  task automatic mul_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] exp_res);
    @(posedge clk); #1;
    set_in(ctrl, a, b, 32'h5A5A_5A5A, pc, rd, 1'b1, 1'b0, 1'b0);
    sb.push_back('{exp_res, b, rd, pc, 1'b1, 1'b0, 1'b0});
    sb_cyc.push_back(cyc + 33);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("mul_stall_high", {31'd0, stall_out}, 32'd1);
    end
    @(negedge clk);
    check("mul_stall_release", {31'd0, stall_out}, 32'd0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    in_valid = 1'b0; flush_in = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    rst = 1'b1; flush_in = 1'b0;
    set_in(4'b1101, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'hFFFF_0000, 5'd31, 1'b1, 1'b1, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_alu", alu_result_out, 32'd0);
    check("rst_store", store_data_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_dest", {27'd0, dest_reg_out}, 32'd0);
    check("rst_valid_en", {28'd0, out_valid, reg_write_en_out, mem_write_en_out, memory_enable_out}, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);

    // ctrl, A, B, I, pc, rd, rwe, mwe, men, expected
    issue(4'b0001, 32'd5, 32'd7, 32'd0, 32'h10, 5'd1, 1, 0, 0, 32'hFFFF_FFFE);
    issue(4'b0111, 32'h8000_0000, 32'd4, 32'd0, 32'h14, 5'd2, 1, 0, 0, 32'hF800_0000);
    issue(4'b0101, 32'h1000, 32'hDEAD, 32'd8, 32'h18, 5'd0, 0, 1, 1, 32'h0000_1008);
    issue(4'b0101, 32'd3, 32'd33, 32'd0, 32'h1C, 5'd3, 1, 0, 0, 32'd6);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h20, 5'd4, 1, 0, 0, 32'd1);
    issue(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h24, 5'd5, 1, 0, 0, 32'd0);
    issue(4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'h28, 5'd6, 1, 0, 0, 32'hFF00_EDCB);
    issue(4'b1011, 32'd9, 32'd9, 32'h1234_5000, 32'h2C, 5'd7, 1, 0, 0, 32'h1234_5000);
    issue(4'b1010, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'h30, 5'd8, 1, 0, 0, 32'd1);
    idle_cycle();

    mul_op(4'b1101, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'h40, 32'hFFFF_FFFE);
    mul_op(4'b1110, 32'hFFFF_FFFF, 32'd2, 5'd10, 32'h44, 32'h0000_0001);
    mul_op(4'b1101, 32'h0001_0000, 32'h0001_0000, 5'd11, 32'h48, 32'd0);
    mul_op(4'b1110, 32'h0001_0000, 32'h0001_0000, 5'd12, 32'h4C, 32'd1);
    mul_op(4'b1101, 32'd7, 32'd6, 5'd13, 32'h50, 32'd42);
    idle_cycle();

    // Flush at BUSY count=10 (cycle N+11): stall drops at once, no result.
    @(posedge clk); #1;
    set_in(4'b1101, 32'd123, 32'd456, 32'd0, 32'h60, 5'd14, 1, 0, 0);
    for (int i = 0; i < 11; i++) @(posedge clk);
    #1 flush_in = 1'b1;
    #1 check("flush_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    flush_in = 1'b0; in_valid = 1'b0;
    #1 check("flush_bubble", {31'd0, out_valid}, 32'd0);
    issue(4'b0000, 32'd3, 32'd4, 32'd0, 32'h64, 5'd15, 1, 0, 0, 32'd7);
    idle_cycle();

    // Flush alongside a multiply in IDLE blocks entry to BUSY.
    @(posedge clk); #1;
    set_in(4'b1110, 32'd99, 32'd99, 32'd0, 32'h70, 5'd16, 1, 0, 0);
    flush_in = 1'b1;
    #1 check("flush_idle_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    flush_in = 1'b0;
    set_in(4'b0011, 32'hA0, 32'h0B, 32'd0, 32'h74, 5'd17, 1, 0, 0);
    sb.push_back('{32'h0000_00AB, 32'h0B, 5'd17, 32'h74, 1'b1, 1'b0, 1'b0});
    sb_cyc.push_back(cyc + 1);
    #1 check("after_flush_no_stall", {31'd0, stall_out}, 32'd0);

    // Back-to-back AUIPC then LINK.
    issue(4'b1100, 32'd0, 32'd0, 32'h2000, 32'h100, 5'd18, 1, 0, 0, 32'h0000_2100);
    issue(4'b1111, 32'd0, 32'd0, 32'd0, 32'h104, 5'd19, 1, 0, 0, 32'h0000_0108);
    idle_cycle();

    // Reset in the middle of a multiply: full reset state, no result.
    @(posedge clk); #1;
    set_in(4'b1101, 32'd5, 32'd5, 32'd0, 32'h80, 5'd20, 1, 0, 0);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_alu", alu_result_out, 32'd0);
    check("midrst_pc", pc_out, 32'd0);
    check("midrst_stall", {31'd0, stall_out}, 32'd0);
    issue(4'b0010, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'h90, 5'd21, 1, 0, 0, 32'h0F00_0F00);
    idle_cycle();

    repeat (40) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RISC-V pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its operands and control signals. It computes ALU results, memory addresses and link values, and runs a 32-cycle iterative shift-add multiplier that stalls the front end while busy. Results are registered into EX/MEM outputs for the memory stage.

## Interface
- `RESET_VALUE`, default 32'd0: reset value of all 32-bit data outputs.
- `MUL_CYCLES`, default 32: iterations of the multiplier. It is fixed at 32, and other values are unsupported.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `flush_in`  in  1: synchronous kill of the instruction presented and of any in-flight multiply.
- `in_valid`  in  1: the ID/EX outputs hold a real instruction.
- `src_data_a_in`  in  32: rs1 value.
- `src_data_b_in`  in  32: rs2 value.
- `imm_value_in`  in  32: immediate.
- `dest_reg_in`  in  5: rd.
- `pc_in`  in  32: instruction PC.
- `ex_control_in`  in  4: operation code.
- `reg_write_en_in`  in  1: register write enable.
- `mem_write_en_in`  in  1: memory write enable.
- `memory_enable_in`  in  1: memory access enable.
- `stall_out`  out  1: combinational. Upstream freezes PC, IF/ID and ID/EX while this is high.
- `out_valid`  out  1: the EX/MEM outputs hold a real instruction.
- `alu_result_out`  out  32: result, or memory address.
- `store_data_out`  out  32: rs2 value, passed through for stores.
- `dest_reg_out`  out  5: registered `dest_reg_in`.
- `pc_out`  out  32: registered `pc_in`.
- `reg_write_en_out`  out  1: registered `reg_write_en_in`.
- `mem_write_en_out`  out  1: registered `mem_write_en_in`.
- `memory_enable_out`  out  1: registered `memory_enable_in`.

## Operation
- **ex_control encoding** (A = `src_data_a_in`, B = `src_data_b_in`, I = `imm_value_in`):
  - 0000 ADD A+B.
  - 0001 SUB A-B.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLL A<<B[4:0].
  - 0110 SRL.
  - 0111 SRA (arithmetic).
  - 1000 SLT (signed, result 0/1).
  - 1001 SLTU (unsigned, result 0/1).
  - 1010 ADDI A+I.
  - 1011 LUI, result I.
  - 1100 AUIPC pc+I.
  - 1101 MUL, low 32 bits of A*B.
  - 1110 MULHU, high 32 bits of unsigned A*B.
  - 1111 LINK pc+4.
- All add, subtract and shift results are taken mod 2^32. Overflow is ignored.
- `memory_enable_in`=1 overrides `ex_control_in`: the result is A+I, and the op is never treated as a multiply.
- `store_data_out` is always the registered B.
- **FSM states:**
  - IDLE:
    - If `in_valid` and the op is 1101/1110 (with `memory_enable_in`=0), capture A, B, the op and the sideband fields, clear the 64-bit accumulator, set count=0 and go to BUSY.
    - Otherwise register the single-cycle result.
  - BUSY:
    - Each cycle, if multiplier bit[count] is set, add (multiplicand << count) into the 64-bit accumulator. Then count++.
    - At count==31, perform the final add and load the output register with acc[31:0] (MUL) or acc[63:32] (MULHU), plus the captured sideband, with `out_valid`=1. Go to IDLE.
- **Bubbles:**
  - During the capture edge and BUSY edges other than the last, the output register loads a bubble.
  - A bubble is `out_valid`=0 with `reg_write_en_out`, `mem_write_en_out` and `memory_enable_out` all 0. Data outputs keep their previous values.
  - `in_valid`=0 in IDLE also loads a bubble.
- **stall_out** = (IDLE & `in_valid` & is_mul & !`flush_in`) | (BUSY & count!=31 & !`flush_in`).
- **Priority:** `rst` > `flush_in` > normal operation. `flush_in` returns the FSM to IDLE, discards the accumulator and loads a bubble.

## Timing
- **Reset:**
  - All data outputs take `RESET_VALUE`; `dest_reg_out`=0; all enables and `out_valid` are 0.
  - FSM goes to IDLE with count=0; `stall_out`=0 in the cycle after reset.
- **Single-cycle op:** presented in cycle N, visible on the outputs in cycle N+1.
- **Multiply:**
  - Presented in cycle N; `stall_out`=1 in cycles N..N+31 and 0 in cycle N+32.
  - The result appears with `out_valid`=1 in cycle N+33.
  - Upstream presents the next instruction in cycle N+33; this block's FSM is IDLE in that cycle.
- **Held inputs:** upstream keeps the inputs stable while `stall_out`=1. This block uses only the values captured on the first edge.
- **Reset mid-multiply:** the next edge enforces the full reset state, with no result.
- **Flush:**
  - `flush_in` in any BUSY cycle, including count==31, kills the multiply. No result is produced, and `stall_out`=0 in that same cycle.
  - `flush_in` together with a multiply presented in IDLE prevents entry to BUSY.

## Test plan
- **Reset:** assert `rst` for 2 cycles with garbage inputs → all outputs 0, `stall_out`=0.
- **SUB then SRA:**
  - SUB with A=5, B=7 → `alu_result_out`=32'hFFFF_FFFE one cycle later.
  - SRA with A=32'h8000_0000, B=4 → 32'hF800_0000.
- **Store:** `memory_enable_in`=1, `mem_write_en_in`=1, `ex_control_in`=0101, A=32'h1000, I=8, B=32'hDEAD → `alu_result_out`=32'h1008, `store_data_out`=32'hDEAD, no stall.
- **MUL and MULHU:**
  - MUL with A=32'hFFFF_FFFF, B=2 → `stall_out` high for exactly 32 cycles; result 32'hFFFF_FFFE with `out_valid`=1 at N+33; bubbles in between.
  - MULHU on the same operands → 32'h0000_0001.
- **Flush mid-multiply:** MUL, then `flush_in` at BUSY count=10 → `stall_out` drops in that cycle, next output is a bubble, FSM is IDLE, and a following ADD 3+4 gives 7 one cycle later.
- **Back-to-back:** AUIPC with pc=32'h100, I=32'h2000 → 32'h2100; immediately followed by LINK with pc=32'h104 → 32'h108 on consecutive cycles with `out_valid`=1 both cycles.
